// File: rtl/csa_stream_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : csa_stream_accumulator
//  Purpose  : Sums an arbitrary-length stream of operands, LANES per beat,
//             into a carry-save (sum/carry) accumulator. After the beat
//             flagged in_last, one ripple carry-propagate add resolves the
//             pair and the total is held on a valid/ready output.
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             in_valid/in_ready - input beat handshake
//             in_data           - LANES packed operands, lane i at [i*WIDTH +: WIDTH]
//             in_lane_en        - per-lane enable (disabled lane adds 0)
//             in_last           - final beat of the stream
//             out_valid/out_ready - result handshake
//             out_sum           - stream total modulo 2^ACC_W
//             out_overflow      - stream carried more than 2^BEAT_W beats
//  Options  : `define CSA_SIGNED_OPS_EN to treat operands as two's complement
//             (sign-extended to ACC_W). Default build: unsigned operands.
//  Revision : 1.0 - initial release
// ============================================================================
module csa_stream_accumulator #(
    parameter int WIDTH  = 7,
    parameter int LANES  = 4,
    parameter int BEAT_W = 4,
    parameter int ACC_W  = WIDTH + $clog2(LANES) + BEAT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   in_data,
    input  logic [LANES-1:0]         in_lane_en,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_W-1:0]         out_sum,
    output logic                     out_overflow
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_RESOLVE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Beat counter saturates at 2^BEAT_W, hence one extra bit.
    localparam logic [BEAT_W:0] c_BEAT_MAX = {1'b1, {BEAT_W{1'b0}}};
    localparam logic [BEAT_W:0] c_CNT_ONE  = {{BEAT_W{1'b0}}, 1'b1};

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc_s;
    logic [ACC_W-1:0]   r_acc_c;
    logic [BEAT_W:0]    r_beat_cnt;
    logic               r_ovf;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_sum;
    logic               r_out_ovf;

    logic               w_accept;
    logic [ACC_W-1:0]   w_op  [LANES];
    logic [ACC_W-1:0]   w_s   [LANES+1];
    logic [ACC_W-1:0]   w_c   [LANES+1];
    logic [ACC_W-1:0]   w_cpa;

    // in_ready is a pure decode of state, forced low while reset is held
    // because the asynchronous reset already parks the state in IDLE.
    assign in_ready     = ((r_state == S_IDLE) || (r_state == S_ACCUM)) && !rst;
    assign w_accept     = in_valid && in_ready;
    assign out_valid    = r_out_valid;
    assign out_sum      = r_out_sum;
    assign out_overflow = r_out_ovf;

    // ------------------------------------------------------------------
    // Operand extension and lane masking
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [WIDTH-1:0] w_raw;
        assign w_raw = in_data[gi*WIDTH +: WIDTH];
`ifdef CSA_SIGNED_OPS_EN
        assign w_op[gi] = in_lane_en[gi] ? {{(ACC_W-WIDTH){w_raw[WIDTH-1]}}, w_raw}
                                         : {ACC_W{1'b0}};
`else
        assign w_op[gi] = in_lane_en[gi] ? {{(ACC_W-WIDTH){1'b0}}, w_raw}
                                         : {ACC_W{1'b0}};
`endif
    end

    // ------------------------------------------------------------------
    // Carry-save reduction: each row of full adders folds one lane into
    // the running (sum, carry) pair, so there is no carry propagation
    // anywhere in the per-beat path. The first beat of a stream (IDLE)
    // starts from a zero pair so no stale total leaks into it.
    // ------------------------------------------------------------------
    assign w_s[0] = (r_state == S_IDLE) ? {ACC_W{1'b0}} : r_acc_s;
    assign w_c[0] = (r_state == S_IDLE) ? {ACC_W{1'b0}} : r_acc_c;

    for (genvar gr = 0; gr < LANES; gr++) begin : g_csa
        logic [ACC_W-1:0] w_maj;
        assign w_maj      = (w_s[gr] & w_c[gr]) | (w_s[gr] & w_op[gr]) | (w_c[gr] & w_op[gr]);
        assign w_s[gr+1]  = w_s[gr] ^ w_c[gr] ^ w_op[gr];
        // Carries move up one weight; the bit shifted past the MSB is the
        // modulo-2^ACC_W wrap and is dropped.
        assign w_c[gr+1]  = {w_maj[ACC_W-2:0], 1'b0};
    end

    // ------------------------------------------------------------------
    // Ripple carry-propagate resolve of the registered pair. The carry out
    // of the MSB is discarded (modulo total; also the correct behaviour
    // for a two's-complement sum).
    // ------------------------------------------------------------------
    always_comb begin
        logic w_cy;
        w_cy  = 1'b0;
        w_cpa = {ACC_W{1'b0}};
        for (int i = 0; i < ACC_W; i++) begin
            w_cpa[i] = r_acc_s[i] ^ r_acc_c[i] ^ w_cy;
            w_cy     = (r_acc_s[i] & r_acc_c[i]) | (w_cy & (r_acc_s[i] ^ r_acc_c[i]));
        end
    end

    // ------------------------------------------------------------------
    // Control and datapath state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc_s     <= {ACC_W{1'b0}};
            r_acc_c     <= {ACC_W{1'b0}};
            r_beat_cnt  <= {(BEAT_W+1){1'b0}};
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= {ACC_W{1'b0}};
            r_out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    // Without an accept the accumulator simply holds, so
                    // idle gaps inside a stream are harmless.
                    if (w_accept) begin
                        r_acc_s <= w_s[LANES];
                        r_acc_c <= w_c[LANES];
                        if (r_beat_cnt == c_BEAT_MAX) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + c_CNT_ONE;
                        end
                        r_state <= in_last ? S_RESOLVE : S_ACCUM;
                    end
                end
                S_RESOLVE: begin
                    r_out_sum   <= w_cpa;
                    r_out_ovf   <= r_ovf;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_beat_cnt  <= {(BEAT_W+1){1'b0}};
                        r_ovf       <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_csa_stream_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csa_stream_accumulator
//  Purpose  : Directed self-checking bench for csa_stream_accumulator with
//             default parameters (WIDTH=7, LANES=4, BEAT_W=4, ACC_W=13).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csa_stream_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [27:0] in_data = '0;
    logic [3:0]  in_lane_en = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [12:0] out_sum;
    logic        out_overflow;

    int checks   = 0;
    int failures = 0;

    csa_stream_accumulator dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_lane_en   (in_lane_en),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one beat, confirm it is accepted on the next rising edge,
    // return just after the following falling edge with in_valid low.
    task automatic beat(input logic [6:0] a0, input logic [6:0] a1,
                        input logic [6:0] a2, input logic [6:0] a3,
                        input logic [3:0] en, input logic last);
        in_data    = {a3, a2, a1, a0};
        in_lane_en = en;
        in_last    = last;
        in_valid   = 1'b1;
        chk("beat_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("consume_valid_low", {31'd0, out_valid}, 32'd0);
        chk("consume_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        // ---------------- reset state ----------------
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_sum", {19'd0, out_sum}, 32'd0);
        chk("rst_out_ovf", {31'd0, out_overflow}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ---------------- single beat, latency ----------------
        beat(7'd1, 7'd2, 7'd3, 7'd4, 4'b1111, 1'b1);
        chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
        chk("resolve_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("sum_1234", {19'd0, out_sum}, 32'd10);
        chk("ovf_1234", {31'd0, out_overflow}, 32'd0);
        chk("done_in_ready", {31'd0, in_ready}, 32'd0);
        consume();

        // ---------------- two beats of max operands ----------------
        beat(7'd127, 7'd127, 7'd127, 7'd127, 4'b1111, 1'b0);
        beat(7'd127, 7'd127, 7'd127, 7'd127, 4'b1111, 1'b1);
        wait_out("max2_valid");
        chk("sum_max2", {19'd0, out_sum}, 32'd1016);
        consume();

        // ---------------- lane masking ----------------
        beat(7'd10, 7'd20, 7'd30, 7'd40, 4'b0101, 1'b1);
        wait_out("mask_valid");
        chk("sum_mask", {19'd0, out_sum}, 32'd40);
        consume();

        // ---------------- idle gap and all-disabled last beat ----------------
        beat(7'd1, 7'd1, 7'd1, 7'd1, 4'b1111, 1'b0);
        repeat (3) @(negedge clk);
        chk("gap_in_ready", {31'd0, in_ready}, 32'd1);
        chk("gap_no_valid", {31'd0, out_valid}, 32'd0);
        beat(7'd9, 7'd9, 7'd9, 7'd9, 4'b0000, 1'b1);
        wait_out("gap_valid");
        chk("sum_gap", {19'd0, out_sum}, 32'd4);
        consume();

        // ---------------- backpressure ----------------
        beat(7'd2, 7'd2, 7'd2, 7'd2, 4'b1111, 1'b1);
        wait_out("bp_valid");
        in_data    = {7'd0, 7'd0, 7'd0, 7'd5};
        in_lane_en = 4'b1111;
        in_last    = 1'b1;
        in_valid   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_sum_stable", {19'd0, out_sum}, 32'd8);
            chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("bp_accepted", {31'd0, in_ready}, 32'd0);
        wait_out("bp_next_valid");
        chk("sum_bp_next", {19'd0, out_sum}, 32'd5);
        consume();

        // ---------------- beat-count overflow ----------------
        for (int i = 0; i < 17; i++) begin
            beat(7'd127, 7'd127, 7'd127, 7'd127, 4'b1111, (i == 16));
        end
        wait_out("ovf_valid");
        chk("sum_ovf", {19'd0, out_sum}, 32'd444);
        chk("ovf_flag", {31'd0, out_overflow}, 32'd1);
        consume();
        beat(7'd5, 7'd0, 7'd0, 7'd0, 4'b1111, 1'b1);
        wait_out("after_ovf_valid");
        chk("sum_after_ovf", {19'd0, out_sum}, 32'd5);
        chk("ovf_cleared", {31'd0, out_overflow}, 32'd0);
        consume();

        // ---------------- 16 beats exactly: no overflow ----------------
        for (int i = 0; i < 16; i++) begin
            beat(7'd1, 7'd0, 7'd0, 7'd0, 4'b0001, (i == 15));
        end
        wait_out("b16_valid");
        chk("sum_b16", {19'd0, out_sum}, 32'd16);
        chk("ovf_b16", {31'd0, out_overflow}, 32'd0);
        consume();

        // ---------------- asynchronous reset mid-stream ----------------
        beat(7'd3, 7'd3, 7'd3, 7'd3, 4'b1111, 1'b0);
        beat(7'd3, 7'd3, 7'd3, 7'd3, 4'b1111, 1'b0);
        beat(7'd3, 7'd3, 7'd3, 7'd3, 4'b1111, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        beat(7'd5, 7'd0, 7'd0, 7'd0, 4'b1111, 1'b1);
        wait_out("arst_valid");
        chk("sum_arst", {19'd0, out_sum}, 32'd5);
        chk("ovf_arst", {31'd0, out_overflow}, 32'd0);
        consume();

`ifdef CSA_SIGNED_OPS_EN
        // ---------------- signed operands: -1 + 1 ----------------
        beat(7'h7F, 7'd1, 7'd0, 7'd0, 4'b1111, 1'b1);
        wait_out("signed_valid");
        chk("sum_signed", {19'd0, out_sum}, 32'd0);
        consume();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
